// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types and constants for the FIFO reader block.
//   state_e    - reader FSM states (IDLE, RUN, GAP, STOP)
//   SKID_DEPTH - number of entries in the output skid buffer
//   SKID_OCCW  - width of the skid occupancy count
//   cnt_width  - burst counter width for a given MAXBURST
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        STOP
    } state_e;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned SKID_OCCW  = $clog2(SKID_DEPTH + 1);

    function automatic int unsigned cnt_width(input int unsigned maxburst);
        return $clog2(maxburst + 1);
    endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry FIFO-ordered valid/ready skid buffer.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (discards contents)
//   push_i       - write push_data_i at the clock edge (ignored when full
//                  unless a handshake frees a slot in the same cycle)
//   push_data_i  - word to store
//   valid_o      - buffer holds at least one word
//   data_o       - oldest stored word
//   ready_i      - downstream accept; handshake = valid_o && ready_i
//   occ_o        - current occupancy (0..SKID_DEPTH)
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     push_data_i,
    output logic                 valid_o,
    output logic [WIDTH-1:0]     data_o,
    input  logic                 ready_i,
    output logic [SKID_OCCW-1:0] occ_o
);

    logic [WIDTH-1:0]     head_q, head_d;
    logic [WIDTH-1:0]     tail_q, tail_d;
    logic [SKID_OCCW-1:0] occ_q, occ_d;
    logic                 pop;
    logic                 push_ok;

    assign pop     = (occ_q != '0) && ready_i;
    assign push_ok = push_i && ((occ_q < SKID_OCCW'(SKID_DEPTH)) || pop);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case (occ_q)
            SKID_OCCW'(0): begin
                if (push_ok) begin
                    head_d = push_data_i;
                    occ_d  = SKID_OCCW'(1);
                end
            end
            SKID_OCCW'(1): begin
                if (push_ok && pop) begin
                    head_d = push_data_i;
                end else if (push_ok) begin
                    tail_d = push_data_i;
                    occ_d  = SKID_OCCW'(2);
                end else if (pop) begin
                    occ_d  = SKID_OCCW'(0);
                end
            end
            default: begin
                // Full: a pop shifts the tail forward; a push may refill it.
                if (pop) begin
                    head_d = tail_q;
                    if (push_ok) begin
                        tail_d = push_data_i;
                    end else begin
                        occ_d  = SKID_OCCW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign valid_o = (occ_q != '0);
    assign data_o  = head_q;
    assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains a show-ahead FIFO read port into a valid/ready stream
// through a 2-entry skid buffer, with burst/gap pacing.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   enable             - draining permitted while high
//   burst_len, gap_len - pacing (burst_len 0 = unlimited), sampled IDLE->RUN
//   f_empty, f_dataout - FIFO show-ahead read side
//   f_pull             - FIFO pop request (combinational)
//   m_valid, m_data    - output stream, m_ready = downstream accept
//   busy               - FSM not in IDLE
//   words_out          - wrapping count of stream handshakes
//   m_parity           - even parity of m_data (only with FIFO_READER_PARITY_EN)
// Optional feature macro: FIFO_READER_PARITY_EN
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned busw     = 32,
    parameter int unsigned MAXBURST = 16,
    parameter int unsigned GAPW     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [cnt_width(MAXBURST)-1:0] burst_len,
    input  logic [GAPW-1:0]               gap_len,
    input  logic                          f_empty,
    input  logic [busw-1:0]               f_dataout,
    output logic                          f_pull,
    output logic                          m_valid,
    output logic [busw-1:0]               m_data,
    input  logic                          m_ready,
    output logic                          busy,
    output logic [31:0]                   words_out
`ifdef FIFO_READER_PARITY_EN
    ,
    output logic                          m_parity
`endif
);

    localparam int unsigned BW = cnt_width(MAXBURST);
`ifdef FIFO_READER_PARITY_EN
    localparam int unsigned SW = busw + 1;
`else
    localparam int unsigned SW = busw;
`endif

    state_e                 state_q, state_d;
    logic [BW-1:0]          burst_cnt_q, burst_cnt_d;
    logic [BW-1:0]          burst_len_q, burst_len_d;
    logic [GAPW-1:0]        gap_cnt_q, gap_cnt_d;
    logic [GAPW-1:0]        gap_len_q, gap_len_d;
    logic [31:0]            words_q, words_d;

    logic [SW-1:0]          skid_in;
    logic [SW-1:0]          skid_out;
    logic [SKID_OCCW-1:0]   occ;
    logic                   handshake;

`ifdef FIFO_READER_PARITY_EN
    assign skid_in  = {^f_dataout, f_dataout};
    assign m_parity = skid_out[busw];
`else
    assign skid_in  = f_dataout;
`endif
    assign m_data = skid_out[busw-1:0];

    fifo_reader_skid #(
        .WIDTH (SW)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (f_pull),
        .push_data_i (skid_in),
        .valid_o     (m_valid),
        .data_o      (skid_out),
        .ready_i     (m_ready),
        .occ_o       (occ)
    );

    // enable is included so that no pop happens on the cycle enable is seen
    // low, even though the state still reads RUN until the next edge.
    assign f_pull    = (state_q == RUN) && enable && !f_empty
                       && (occ < SKID_OCCW'(SKID_DEPTH));
    assign handshake = m_valid && m_ready;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        burst_len_d = burst_len_q;
        gap_cnt_d   = gap_cnt_q;
        gap_len_d   = gap_len_q;
        words_d     = handshake ? words_q + 32'd1 : words_q;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d     = RUN;
                    burst_cnt_d = burst_len;
                    burst_len_d = burst_len;
                    gap_cnt_d   = gap_len;
                    gap_len_d   = gap_len;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = STOP;
                end else if (f_pull && (burst_len_q != '0)) begin
                    if (burst_cnt_q == BW'(1)) begin
                        // Burst complete: zero gap chains straight into the next burst.
                        if (gap_len_q == '0) begin
                            burst_cnt_d = burst_len_q;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = gap_len_q;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q - BW'(1);
                    end
                end
            end
            GAP: begin
                if (!enable) begin
                    state_d = STOP;
                end else if (gap_cnt_q <= GAPW'(1)) begin
                    state_d     = RUN;
                    burst_cnt_d = burst_len_q;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAPW'(1);
                end
            end
            STOP: begin
                if (occ == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            burst_len_q <= '0;
            gap_cnt_q   <= '0;
            gap_len_q   <= '0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            burst_len_q <= burst_len_d;
            gap_cnt_q   <= gap_cnt_d;
            gap_len_q   <= gap_len_d;
            words_q     <= words_d;
        end
    end

    assign words_out = words_q;

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [4:0]  burst_len;
    logic [3:0]  gap_len;
    logic        f_empty;
    logic [31:0] f_dataout;
    logic        f_pull;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;
    logic        busy;
    logic [31:0] words_out;
`ifdef FIFO_READER_PARITY_EN
    logic        m_parity;
`endif

    fifo_reader #(
        .busw     (32),
        .MAXBURST (16),
        .GAPW     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .burst_len (burst_len),
        .gap_len   (gap_len),
        .f_empty   (f_empty),
        .f_dataout (f_dataout),
        .f_pull    (f_pull),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .busy      (busy),
        .words_out (words_out)
`ifdef FIFO_READER_PARITY_EN
        ,
        .m_parity  (m_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned nvec = 0;
    int unsigned nmis = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] pat;
    int unsigned pat_n;
    logic        prev_pull;
    logic        lat_chk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        f_empty   = (fifo_q.size() == 0);
        f_dataout = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push_words(input logic [31:0] base, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) fifo_q.push_back(base + i);
        refresh();
    endtask

    task automatic start_pattern();
        pat   = '0;
        pat_n = 0;
    endtask

    // Pull pattern expected from the enable cycle: one IDLE cycle, then
    // bursts of bl pulls separated by gl idle cycles until n words are taken.
    function automatic logic [31:0] exp_pattern(input int unsigned n, input int unsigned bl,
                                               input int unsigned gl);
        logic [31:0] p;
        int unsigned idx, rem, b;
        p   = '0;
        idx = 1;
        rem = n;
        while (rem > 0 && idx < 32) begin
            b = 0;
            while ((bl == 0 || b < bl) && rem > 0 && idx < 32) begin
                p[idx] = 1'b1;
                idx++;
                rem--;
                b++;
            end
            if (rem > 0) idx += gl;
        end
        return p;
    endfunction

    // One clock: sample at negedge, model the FIFO pop after the posedge.
    task automatic cycle();
        logic        pull, hs, was_rst;
        logic [31:0] e;
        @(negedge clk);
        pull    = f_pull;
        hs      = m_valid && m_ready;
        was_rst = rst;
        if (!was_rst) begin
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk_eq("sb_empty", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk_eq("sb_data", m_data, e);
`ifdef FIFO_READER_PARITY_EN
                    chk_eq("sb_parity", m_parity, ^e);
`endif
                end
            end
            if (pull && fifo_q.size() > 0) exp_q.push_back(fifo_q[0]);
        end
        if (lat_chk) chk_eq("lat_valid", m_valid, prev_pull);
        prev_pull = pull;
        if (pat_n < 32) pat[pat_n] = pull;
        pat_n++;
        @(posedge clk);
        #1;
        if (pull && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (was_rst) exp_q.delete();
        refresh();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        enable    = 1'b0;
        m_ready   = 1'b0;
        burst_len = '0;
        gap_len   = '0;
        lat_chk   = 1'b0;
        fifo_q.delete();
        refresh();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic timed_out;
        rst = 1'b1; enable = 1'b0; m_ready = 1'b0; burst_len = '0; gap_len = '0;
        prev_pull = 1'b0; lat_chk = 1'b0; pat = '0; pat_n = 0;
        refresh();

        // Reset state
        do_reset();
        chk_eq("rst_valid", m_valid, 0);
        chk_eq("rst_data", m_data, 0);
        chk_eq("rst_pull", f_pull, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_words", words_out, 0);

        // 1: unlimited burst, 8 words back to back
        push_words(32'h11, 8);
        burst_len = 5'd0; m_ready = 1'b1; enable = 1'b1; lat_chk = 1'b1;
        prev_pull = 1'b0;
        start_pattern();
        for (int i = 0; i < 14; i++) cycle();
        chk_eq("t1_pulls", pat & 32'h3fff, exp_pattern(8, 0, 0));
        chk_eq("t1_words", words_out, 8);
        chk_eq("t1_pull_empty", f_pull, 0);
        chk_eq("t1_busy_run", busy, 1);
        chk_eq("t1_sb_left", exp_q.size(), 0);

        // 2: burst 3, gap 2, 10 words
        do_reset();
        push_words(32'h200, 10);
        burst_len = 5'd3; gap_len = 4'd2; m_ready = 1'b1; enable = 1'b1; lat_chk = 1'b1;
        prev_pull = 1'b0;
        start_pattern();
        for (int i = 0; i < 28; i++) cycle();
        chk_eq("t2_pulls", pat & 32'h0fff_ffff, exp_pattern(10, 3, 2));
        chk_eq("t2_words", words_out, 10);
        lat_chk = 1'b0;

        // 3: backpressure, buffer fills then stalls stable
        do_reset();
        push_words(32'hA0, 6);
        m_ready = 1'b0; enable = 1'b1;
        start_pattern();
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i >= 1) begin
                chk_eq("t3_valid_hold", m_valid, 1);
                chk_eq("t3_data_hold", m_data, 32'hA0);
            end
        end
        chk_eq("t3_pulls", pat & 32'h3f, exp_pattern(2, 0, 0));
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
        chk_eq("t3_words", words_out, 6);
        chk_eq("t3_sb_left", exp_q.size(), 0);

        // 4: enable dropped with a full skid buffer
        do_reset();
        push_words(32'hB0, 5);
        m_ready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        enable = 1'b0;
        start_pattern();
        cycle();
        cycle();
        m_ready = 1'b1;
        timed_out = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (!m_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
        chk_eq("t4_drain_timeout", timed_out, 0);
        chk_eq("t4_busy_stop", busy, 1);
        cycle();
        chk_eq("t4_busy_idle", busy, 0);
        chk_eq("t4_pulls", pat, 0);
        chk_eq("t4_words", words_out, 2);
        chk_eq("t4_fifo_left", fifo_q.size(), 3);

        // 5: reset while full in RUN
        do_reset();
        push_words(32'hC0, 4);
        m_ready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk_eq("t5_full_valid", m_valid, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk_eq("t5_valid", m_valid, 0);
        chk_eq("t5_pull", f_pull, 0);
        chk_eq("t5_busy", busy, 0);
        chk_eq("t5_words0", words_out, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        chk_eq("t5_words", words_out, 2);
        chk_eq("t5_sb_left", exp_q.size(), 0);

        // 6: parity-sensitive words 1 and 3
        do_reset();
        fifo_q.push_back(32'h1);
        fifo_q.push_back(32'h3);
        refresh();
        m_ready = 1'b1; enable = 1'b1;
        cycle();
        cycle();
        chk_eq("t6_data1", m_data, 32'h1);
`ifdef FIFO_READER_PARITY_EN
        chk_eq("t6_par1", m_parity, 1);
`endif
        cycle();
        chk_eq("t6_data3", m_data, 32'h3);
`ifdef FIFO_READER_PARITY_EN
        chk_eq("t6_par3", m_parity, 0);
`endif
        for (int i = 0; i < 3; i++) cycle();
        chk_eq("t6_words", words_out, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
